lcd_line_arbiter: RTL and testbench
===================================

# lcd_line_arbiter

Shares the single HD44780 byte-write path between several requesters that each want to rewrite a full 16-character LCD line (score line, status line, transient banners). Grants one requester at a time with round-robin fairness. For each grant it sequences one set-DDRAM-address command followed by LINE_LEN data bytes into the downstream LCD byte driver over a valid/ready handshake. Sits between the screen-content producers and the low-level LCD timing driver. The driver owns the E-pulse timing and the power-on init and holds wr_ready low until init completes.

## Interface
- NUM_REQ, default 3: number of requesters (≥2).
- LINE_LEN, default 16: characters per line write.
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester level request; held until the matching done pulse.
- req_line  in  NUM_REQ  target line per requester: 0 → command 0x80, 1 → command 0xC0.
- req_char  in  NUM_REQ*8  character byte of requester i on bits [8i+7:8i]. Must combinationally reflect the character at char_idx.
- grant  out  NUM_REQ  one-hot index of the active requester; all zero when idle.
- char_idx  out  4  index of the character currently being fetched.
- done  out  NUM_REQ  one-cycle pulse on the granted bit when its line write completes.
- busy  out  1  high whenever the FSM is not in IDLE.
- wr_valid  out  1  byte offered to the driver.
- wr_rs  out  1  0 = command, 1 = data.
- wr_data  out  8  byte to write.
- wr_ready  in  1  driver can accept a byte. A transfer occurs on any cycle where wr_valid and wr_ready are both high.

## Operation
- **States:** IDLE, CMD, LOAD, DATA, DONE. All outputs are registered.
- **IDLE:**
  - Samples req only in this state.
  - If any req bit is high, selects the first set bit searching upward (with wrap) from rr_ptr+1.
  - In the same transition: latches the winner into grant, sets wr_valid=1, wr_rs=0, wr_data = 0x80 or 0xC0 from req_line[winner], and moves to CMD.
- **CMD:** holds the command byte until it transfers. On transfer: char_idx←0, wr_valid←0, move to LOAD.
- **LOAD:** wr_data←req_char[grant], wr_rs←1, wr_valid←1, move to DATA.
- **DATA:** holds the byte until it transfers. On transfer:
  - If char_idx==LINE_LEN-1: wr_valid←0, move to DONE.
  - Otherwise: char_idx←char_idx+1, wr_valid←0, move to LOAD.
- **DONE:** done[grant]←1 for this one cycle. rr_ptr←granted index. Next cycle: grant←0, char_idx←0, rr_ptr kept, move to IDLE.
- **Handshake rules:**
  - wr_valid never drops, and wr_data/wr_rs never change, while a byte is pending and not yet accepted.
  - wr_valid is low in LOAD, DONE and IDLE.
- **req dropped mid-transaction:** ignored; the line write completes and done still pulses.
- **Requester contract:** deassert req on the cycle after done. A req still high when the FSM returns to IDLE is treated as a new request.
- **req_line / req_char changes:** req_line is sampled only at grant. req_char is sampled only in LOAD.
- **Reset:**
  - Asynchronous, allowed mid-transaction; the aborted line is not resumed.
  - Reset values: state IDLE; grant 0; char_idx 0; done 0; busy 0; wr_valid 0; wr_rs 0; wr_data 0x00; rr_ptr = NUM_REQ-1, so requester 0 has top priority after reset.
  - The downstream driver must tolerate wr_valid dropping asynchronously.

## Timing
- **No backpressure** (wr_ready=1, req rising in IDLE at cycle t):
  - Command byte valid at t+1.
  - Character k valid at t+3+2k.
  - Last character transfers at t+33.
  - done pulses at t+34; IDLE at t+35. Total 35 cycles per line (LINE_LEN=16).
- **Backpressure:** each cycle of wr_ready=0 while wr_valid=1 stretches the pending byte by exactly one cycle.
- **Fairness:** a continuously requesting requester waits at most NUM_REQ-1 full line writes.
- **grant:** stable from t+1 through the DONE cycle inclusive.

## Test plan
- **Single requester:** req[0]=1, req_line[0]=0, chars "ROUND 3" padded with spaces, wr_ready=1. Expect transfers 0x80 (rs=0), then 16 bytes with rs=1 matching the string; done[0] at t+34; busy low at t+35.
- **Backpressure:** wr_ready=0 for 5 cycles while char_idx=3 is pending. wr_valid, wr_data and char_idx stay constant for the whole stall; exactly 17 transfers total, no duplicates or skips.
- **Round-robin:** req[2:0] held at 3'b111, each requester re-raising after its done. Grant order 0,1,2,0,1; no overlap between grants.
- **First-after-reset priority:** reset, then req[1] and req[2] both rise in the same cycle. Requester 1 is granted first, then 2. req_line[2]=1 produces command 0xC0.
- **Withdrawal:** req[0] dropped after char 5. The burst still completes all 16 characters; done[0] still pulses.
- **Reset mid-burst:** reset_n low during char 8. All outputs read zero immediately. After release with req[1] high, a fresh line starts with the command byte.

Source files
------------

// File: rtl/lcd_line_arbiter_if.sv
// Handshake bundle between line producers, the line arbiter and the LCD byte driver.
// The slave modport is the arbiter's view; master is the producer/driver side.
interface lcd_line_arbiter_if #(
  parameter int unsigned NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_line;
  logic [NUM_REQ*8-1:0] req_char;
  logic [NUM_REQ-1:0]   grant;
  logic [3:0]           char_idx;
  logic [NUM_REQ-1:0]   done;
  logic                 busy;
  logic                 wr_valid;
  logic                 wr_rs;
  logic [7:0]           wr_data;
  logic                 wr_ready;

  modport master (
    output req, req_line, req_char, wr_ready,
    input  grant, char_idx, done, busy, wr_valid, wr_rs, wr_data
  );

  modport slave (
    input  req, req_line, req_char, wr_ready,
    output grant, char_idx, done, busy, wr_valid, wr_rs, wr_data
  );
endinterface

// File: rtl/lcd_line_arbiter.sv
// Round-robin arbiter that streams one set-DDRAM-address command plus LINE_LEN
// characters per grant into the HD44780 byte driver over valid/ready.
module lcd_line_arbiter #(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned LINE_LEN = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  lcd_line_arbiter_if.slave    line_if
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LOAD,
    ST_DATA,
    ST_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [3:0]           char_idx_q, char_idx_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 wr_valid_q, wr_valid_d;
  logic                 wr_rs_q, wr_rs_d;
  logic [7:0]           wr_data_q, wr_data_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic                 xfer;
  logic                 last_char;

  assign xfer      = wr_valid_q & line_if.wr_ready;
  assign last_char = (char_idx_q == 4'(LINE_LEN - 1));

  // First pending request searching upward from rr_ptr+1 with wrap.
  always_comb begin : arb_comb
    logic [IDX_W-1:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && line_if.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : state_reg
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
      char_idx_q <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_rs_q    <= 1'b0;
      wr_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      char_idx_q <= char_idx_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_rs_q    <= wr_rs_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin : next_state_comb
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (win_found) state_d = ST_CMD;
      ST_CMD:  if (xfer) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_DATA;
      ST_DATA: if (xfer) state_d = last_char ? ST_DONE : ST_LOAD;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pending bytes hold until accepted; only transitions touch the byte registers.
  always_comb begin : output_comb
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    char_idx_d = char_idx_q;
    done_d     = '0;
    wr_valid_d = wr_valid_q;
    wr_rs_d    = wr_rs_q;
    wr_data_d  = wr_data_q;
    busy_d     = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d    = NUM_REQ'(1) << win_idx;
          gidx_d     = win_idx;
          wr_valid_d = 1'b1;
          wr_rs_d    = 1'b0;
          wr_data_d  = line_if.req_line[win_idx] ? 8'hC0 : 8'h80;
        end
      end
      ST_CMD: begin
        if (xfer) begin
          char_idx_d = '0;
          wr_valid_d = 1'b0;
        end
      end
      ST_LOAD: begin
        wr_data_d  = line_if.req_char[{gidx_q, 3'b000} +: 8];
        wr_rs_d    = 1'b1;
        wr_valid_d = 1'b1;
      end
      ST_DATA: begin
        if (xfer) begin
          wr_valid_d = 1'b0;
          if (last_char) begin
            done_d = grant_q;
          end else begin
            char_idx_d = char_idx_q + 4'd1;
          end
        end
      end
      ST_DONE: begin
        grant_d    = '0;
        char_idx_d = '0;
        rr_ptr_d   = gidx_q;
      end
      default: ;
    endcase
  end

  assign line_if.grant    = grant_q;
  assign line_if.char_idx = char_idx_q;
  assign line_if.done     = done_q;
  assign line_if.busy     = busy_q;
  assign line_if.wr_valid = wr_valid_q;
  assign line_if.wr_rs    = wr_rs_q;
  assign line_if.wr_data  = wr_data_q;

endmodule

// File: tb/tb_lcd_line_arbiter.sv
// Randomized bench for lcd_line_arbiter: a queue-based model predicts grant order
// and the byte stream of every line write; each scenario task checks its own results.
module tb_lcd_line_arbiter;
  localparam int unsigned NR = 3;
  localparam int unsigned LL = 16;
  localparam int          BPL = 17;

  logic clk = 1'b0;
  logic reset_n;

  lcd_line_arbiter_if #(.NUM_REQ(NR)) bus ();

  lcd_line_arbiter #(.NUM_REQ(NR), .LINE_LEN(LL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .line_if (bus)
  );

  always #10 clk = ~clk;

  typedef struct { logic rs; logic [7:0] data; int cyc; logic [NR-1:0] gnt; } xfer_t;
  typedef struct { logic rs; logic [7:0] data; } byte_t;
  typedef struct { logic [NR-1:0] d; int cyc; } done_t;

  xfer_t xfer_log[$];
  done_t done_log[$];
  byte_t exp_bytes[$];
  int    exp_win[$];

  logic [7:0] line_mem [NR][LL];
  int  cyc = 0;
  int  m_last;
  int  ovl_errs, idle_cyc, stall_var_errs, drop_cyc;
  logic busy_prev = 1'b0;
  bit  rand_content;
  int  want [NR];
  bit  timed_out;
  int  pass_cnt = 0;
  int  chk_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Producers present the character at char_idx combinationally.
  always_comb begin
    for (int i = 0; i < int'(NR); i++) bus.req_char[8*i +: 8] = line_mem[i][bus.char_idx];
  end

  // Observation log plus the reference model: every IDLE cycle with a pending request
  // is an arbitration; the winner is the next requester after the last one served.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.wr_valid && bus.wr_ready) xfer_log.push_back('{bus.wr_rs, bus.wr_data, cyc, bus.grant});
      if (bus.done != '0) done_log.push_back('{bus.done, cyc});
      if (!$onehot0(bus.grant)) ovl_errs++;
      if (busy_prev && !bus.busy) idle_cyc = cyc;
      busy_prev = bus.busy;
      if (!bus.busy && bus.req != '0) begin
        int w;
        w = -1;
        for (int k = 1; k <= int'(NR); k++) begin
          int j;
          j = (m_last + k) % int'(NR);
          if (w < 0 && bus.req[j]) w = j;
        end
        exp_win.push_back(w);
        m_last = w;
        exp_bytes.push_back('{1'b0, bus.req_line[w] ? 8'hC0 : 8'h80});
        for (int k = 0; k < int'(LL); k++) exp_bytes.push_back('{1'b1, line_mem[w][k]});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  function automatic void clear_logs();
    xfer_log.delete(); done_log.delete(); exp_bytes.delete(); exp_win.delete();
    ovl_errs = 0; idle_cyc = -1; stall_var_errs = 0; drop_cyc = -1; busy_prev = 1'b0;
  endfunction

  // Mismatches between the observed byte stream and the model's prediction.
  function automatic int count_byte_errs();
    int e = 0;
    int n = (xfer_log.size() < exp_bytes.size()) ? xfer_log.size() : exp_bytes.size();
    for (int j = 0; j < n; j++) begin
      if (xfer_log[j].rs !== exp_bytes[j].rs || xfer_log[j].data !== exp_bytes[j].data) e++;
      if (j / BPL < exp_win.size() && xfer_log[j].gnt !== (NR'(1) << exp_win[j / BPL])) e++;
    end
    return e;
  endfunction

  function automatic int count_order_errs();
    int e = 0;
    for (int j = 0; j < done_log.size(); j++)
      if (j >= exp_win.size() || done_log[j].d !== (NR'(1) << exp_win[j])) e++;
    return e;
  endfunction

  task automatic reset_dut();
    reset_n = 1'b0;
    bus.req = '0;
    bus.wr_ready = 1'b1;
    for (int i = 0; i < int'(NR); i++) want[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    m_last = int'(NR) - 1;
    reset_n = 1'b1;
  endtask

  // Requester/driver behaviour: raise while lines are wanted, drop the cycle after done,
  // random or forced backpressure, optional mid-burst withdrawal.
  task automatic run(input int budget, input int stall_pct, input int drop_idx, input int stall_idx);
    int n = 0;
    logic [NR-1:0] dseen = '0;
    int stall_left = 0;
    bit stall_used = 1'b0;
    logic [7:0] snap_data = '0;
    logic [3:0] snap_idx = '0;
    bit all_done;
    timed_out = 1'b0;
    forever begin
      if (n >= budget) begin timed_out = 1'b1; break; end
      @(posedge clk);
      #1;
      n++;
      for (int i = 0; i < int'(NR); i++) begin
        if (dseen[i]) begin
          bus.req[i] = 1'b0;
          if (want[i] > 0) want[i]--;
        end else if (!bus.req[i] && want[i] > 0) begin
          if (rand_content) begin
            bus.req_line[i] = 1'($urandom_range(0, 1));
            for (int k = 0; k < int'(LL); k++) line_mem[i][k] = 8'($urandom_range(32, 126));
          end
          bus.req[i] = 1'b1;
        end
      end
      if (drop_idx >= 0 && bus.grant[drop_idx] && bus.req[drop_idx] && bus.char_idx > 4'd5) begin
        bus.req[drop_idx] = 1'b0;
        want[drop_idx] = 0;
        drop_cyc = cyc;
      end
      if (stall_idx >= 0 && !stall_used && bus.wr_valid && bus.wr_rs && bus.char_idx == 4'(stall_idx)) begin
        stall_used = 1'b1; stall_left = 5; snap_data = bus.wr_data; snap_idx = bus.char_idx;
      end
      if (stall_left > 0) begin
        if (bus.wr_valid !== 1'b1 || bus.wr_data !== snap_data || bus.char_idx !== snap_idx) stall_var_errs++;
        stall_left--;
        bus.wr_ready = 1'b0;
      end else begin
        bus.wr_ready = ($urandom_range(0, 99) >= 32'(stall_pct));
      end
      dseen = bus.done;
      all_done = (bus.req == '0) && !bus.busy;
      for (int i = 0; i < int'(NR); i++) if (want[i] != 0) all_done = 1'b0;
      if (all_done) break;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.req = '0; bus.req_line = '0; bus.wr_ready = 1'b1;
    for (int i = 0; i < int'(NR); i++) begin
      want[i] = 0;
      for (int k = 0; k < int'(LL); k++) line_mem[i][k] = 8'h20;
    end
    clear_logs();
    m_last = int'(NR) - 1;
    #1;
    chk_cnt++; if (bus.grant !== 3'b000) $display("FAIL reset_grant: got %b want 000", bus.grant); else pass_cnt++;
    chk_cnt++; if (bus.char_idx !== 4'd0) $display("FAIL reset_char_idx: got %0d want 0", bus.char_idx); else pass_cnt++;
    chk_cnt++; if (bus.done !== 3'b000) $display("FAIL reset_done: got %b want 000", bus.done); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
    chk_cnt++; if (bus.wr_valid !== 1'b0) $display("FAIL reset_wr_valid: got %b want 0", bus.wr_valid); else pass_cnt++;
    chk_cnt++; if (bus.wr_rs !== 1'b0) $display("FAIL reset_wr_rs: got %b want 0", bus.wr_rs); else pass_cnt++;
    chk_cnt++; if (bus.wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h want 00", bus.wr_data); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    string s = "ROUND 3";
    int t, terr;
    rand_content = 1'b0;
    for (int k = 0; k < int'(LL); k++) line_mem[0][k] = (k < s.len()) ? s[k] : 8'h20;
    bus.req_line[0] = 1'b0;
    @(posedge clk);
    #1;
    bus.req[0] = 1'b1; want[0] = 1; t = cyc;
    run(200, 0, -1, -1);
    chk_cnt++; if (timed_out !== 1'b0) $display("FAIL single_timeout: got timeout want completion"); else pass_cnt++;
    chk_cnt++; if (xfer_log.size() !== BPL) $display("FAIL single_count: got %0d want %0d", xfer_log.size(), BPL); else pass_cnt++;
    chk_cnt++; if (count_byte_errs() !== 0) $display("FAIL single_bytes: got %0d mismatches want 0", count_byte_errs()); else pass_cnt++;
    if (xfer_log.size() == BPL) begin
      chk_cnt++; if (xfer_log[0].data !== 8'h80 || xfer_log[0].rs !== 1'b0) $display("FAIL single_cmd: got %h rs %b want 80 rs 0", xfer_log[0].data, xfer_log[0].rs); else pass_cnt++;
      chk_cnt++; if (xfer_log[1].data !== 8'h52) $display("FAIL single_first_char: got %h want 52", xfer_log[1].data); else pass_cnt++;
      chk_cnt++; if (xfer_log[0].cyc !== t + 1) $display("FAIL single_cmd_time: got %0d want %0d", xfer_log[0].cyc, t + 1); else pass_cnt++;
      terr = 0;
      for (int k = 0; k < int'(LL); k++) if (xfer_log[k+1].cyc !== t + 3 + 2*k) terr++;
      chk_cnt++; if (terr !== 0) $display("FAIL single_char_times: got %0d late/early chars want 0", terr); else pass_cnt++;
    end
    chk_cnt++; if (done_log.size() !== 1 || done_log[0].d !== 3'b001 || done_log[0].cyc !== t + 34)
      $display("FAIL single_done: got %0d pulses, first at %0d want 1 pulse 001 at %0d", done_log.size(), (done_log.size() > 0) ? done_log[0].cyc : -1, t + 34); else pass_cnt++;
    chk_cnt++; if (idle_cyc !== t + 35) $display("FAIL single_idle: got busy low at %0d want %0d", idle_cyc, t + 35); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    clear_logs();
    rand_content = 1'b1;
    want[2] = 1;
    run(300, 0, -1, 3);
    chk_cnt++; if (timed_out !== 1'b0) $display("FAIL bp_timeout: got timeout want completion"); else pass_cnt++;
    chk_cnt++; if (xfer_log.size() !== BPL) $display("FAIL bp_count: got %0d want %0d", xfer_log.size(), BPL); else pass_cnt++;
    chk_cnt++; if (count_byte_errs() !== 0) $display("FAIL bp_bytes: got %0d mismatches want 0", count_byte_errs()); else pass_cnt++;
    chk_cnt++; if (stall_var_errs !== 0) $display("FAIL bp_hold: got %0d changed cycles want 0", stall_var_errs); else pass_cnt++;
    if (xfer_log.size() == BPL) begin
      chk_cnt++; if (xfer_log[4].cyc - xfer_log[3].cyc !== 7) $display("FAIL bp_stretch: got gap %0d want 7", xfer_log[4].cyc - xfer_log[3].cyc); else pass_cnt++;
      chk_cnt++; if (xfer_log[5].cyc - xfer_log[4].cyc !== 2) $display("FAIL bp_resume: got gap %0d want 2", xfer_log[5].cyc - xfer_log[4].cyc); else pass_cnt++;
    end
    chk_cnt++; if (done_log.size() !== 1 || count_order_errs() !== 0) $display("FAIL bp_done: got %0d pulses want 1 on grant", done_log.size()); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int rr_exp [5] = '{0, 1, 2, 0, 1};
    int oerr = 0;
    reset_dut();
    rand_content = 1'b1;
    want[0] = 2; want[1] = 2; want[2] = 1;
    run(1500, 20, -1, -1);
    chk_cnt++; if (timed_out !== 1'b0) $display("FAIL rr_timeout: got timeout want completion"); else pass_cnt++;
    chk_cnt++; if (done_log.size() !== 5) $display("FAIL rr_done_count: got %0d want 5", done_log.size()); else pass_cnt++;
    for (int j = 0; j < done_log.size() && j < 5; j++) if (done_log[j].d !== (NR'(1) << rr_exp[j])) oerr++;
    chk_cnt++; if (oerr !== 0) $display("FAIL rr_order: got %0d out-of-order grants want 0", oerr); else pass_cnt++;
    chk_cnt++; if (count_order_errs() !== 0) $display("FAIL rr_model_order: got %0d mismatches want 0", count_order_errs()); else pass_cnt++;
    chk_cnt++; if (xfer_log.size() !== 5*BPL || count_byte_errs() !== 0)
      $display("FAIL rr_bytes: got %0d bytes %0d mismatches want %0d bytes 0 mismatches", xfer_log.size(), count_byte_errs(), 5*BPL); else pass_cnt++;
    chk_cnt++; if (ovl_errs !== 0) $display("FAIL rr_overlap: got %0d multi-grant cycles want 0", ovl_errs); else pass_cnt++;
  endtask

  task automatic test_first_priority();
    reset_dut();
    rand_content = 1'b0;
    for (int i = 1; i < 3; i++) for (int k = 0; k < int'(LL); k++) line_mem[i][k] = 8'($urandom_range(32, 126));
    bus.req_line[1] = 1'b0; bus.req_line[2] = 1'b1;
    @(posedge clk);
    #1;
    bus.req = 3'b110; want[1] = 1; want[2] = 1;
    run(400, 0, -1, -1);
    chk_cnt++; if (done_log.size() !== 2) $display("FAIL prio_count: got %0d want 2", done_log.size()); else pass_cnt++;
    if (done_log.size() == 2) begin
      chk_cnt++; if (done_log[0].d !== 3'b010) $display("FAIL prio_first: got %b want 010", done_log[0].d); else pass_cnt++;
      chk_cnt++; if (done_log[1].d !== 3'b100) $display("FAIL prio_second: got %b want 100", done_log[1].d); else pass_cnt++;
    end
    if (xfer_log.size() == 2*BPL) begin
      chk_cnt++; if (xfer_log[0].data !== 8'h80) $display("FAIL prio_cmd1: got %h want 80", xfer_log[0].data); else pass_cnt++;
      chk_cnt++; if (xfer_log[BPL].data !== 8'hC0 || xfer_log[BPL].rs !== 1'b0) $display("FAIL prio_cmd2: got %h rs %b want C0 rs 0", xfer_log[BPL].data, xfer_log[BPL].rs); else pass_cnt++;
    end
    chk_cnt++; if (xfer_log.size() !== 2*BPL || count_byte_errs() !== 0) $display("FAIL prio_bytes: got %0d bytes %0d mismatches", xfer_log.size(), count_byte_errs()); else pass_cnt++;
  endtask

  task automatic test_withdrawal();
    clear_logs();
    rand_content = 1'b1;
    want[0] = 1;
    run(400, 25, 0, -1);
    chk_cnt++; if (timed_out !== 1'b0) $display("FAIL wd_timeout: got timeout want completion"); else pass_cnt++;
    chk_cnt++; if (xfer_log.size() !== BPL || count_byte_errs() !== 0) $display("FAIL wd_bytes: got %0d bytes %0d mismatches want %0d and 0", xfer_log.size(), count_byte_errs(), BPL); else pass_cnt++;
    chk_cnt++; if (done_log.size() !== 1 || done_log[0].d !== 3'b001) $display("FAIL wd_done: got %0d pulses want one on 001", done_log.size()); else pass_cnt++;
    chk_cnt++; if (drop_cyc < 0 || done_log.size() < 1 || done_log[0].cyc <= drop_cyc) $display("FAIL wd_order: got drop %0d done %0d want done after drop", drop_cyc, (done_log.size() > 0) ? done_log[0].cyc : -1); else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    bit hit = 1'b0;
    reset_dut();
    rand_content = 1'b1;
    for (int k = 0; k < int'(LL); k++) line_mem[1][k] = 8'($urandom_range(32, 126));
    bus.req_line[1] = 1'b1;
    @(posedge clk);
    #1;
    bus.req[1] = 1'b1;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(posedge clk);
      #1;
      if (bus.wr_valid && bus.wr_rs && bus.char_idx == 4'd8) hit = 1'b1;
    end
    chk_cnt++; if (hit !== 1'b1) $display("FAIL rst_mid_reach: got no char 8 within 100 cycles want char 8"); else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    chk_cnt++; if (bus.grant !== 3'b000 || bus.busy !== 1'b0 || bus.done !== 3'b000)
      $display("FAIL rst_mid_ctrl: got grant %b busy %b done %b want all zero", bus.grant, bus.busy, bus.done); else pass_cnt++;
    chk_cnt++; if (bus.wr_valid !== 1'b0 || bus.wr_rs !== 1'b0 || bus.wr_data !== 8'h00 || bus.char_idx !== 4'd0)
      $display("FAIL rst_mid_bus: got valid %b rs %b data %h idx %0d want all zero", bus.wr_valid, bus.wr_rs, bus.wr_data, bus.char_idx); else pass_cnt++;
    clear_logs();
    m_last = int'(NR) - 1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    want[1] = 1;
    run(400, 10, -1, -1);
    chk_cnt++; if (xfer_log.size() < 1 || xfer_log[0].rs !== 1'b0 || xfer_log[0].data !== 8'hC0)
      $display("FAIL rst_mid_restart: got first byte %h rs %b want C0 rs 0", (xfer_log.size() > 0) ? xfer_log[0].data : 8'h00, (xfer_log.size() > 0) ? xfer_log[0].rs : 1'b1); else pass_cnt++;
    chk_cnt++; if (xfer_log.size() !== BPL || count_byte_errs() !== 0) $display("FAIL rst_mid_bytes: got %0d bytes %0d mismatches", xfer_log.size(), count_byte_errs()); else pass_cnt++;
    chk_cnt++; if (done_log.size() !== 1 || done_log[0].d !== 3'b010) $display("FAIL rst_mid_done: got %0d pulses want one on 010", done_log.size()); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int total = 0;
      clear_logs();
      rand_content = 1'b1;
      for (int i = 0; i < int'(NR); i++) want[i] = $urandom_range(0, 2);
      if (want[r % int'(NR)] == 0) want[r % int'(NR)] = 1;
      for (int i = 0; i < int'(NR); i++) total += want[i];
      run(3000, 30, -1, -1);
      chk_cnt++; if (timed_out !== 1'b0 || done_log.size() !== total) $display("FAIL rand%0d_lines: got %0d lines timeout %b want %0d", r, done_log.size(), timed_out, total); else pass_cnt++;
      chk_cnt++; if (count_order_errs() !== 0) $display("FAIL rand%0d_order: got %0d mismatches want 0", r, count_order_errs()); else pass_cnt++;
      chk_cnt++; if (xfer_log.size() !== total*BPL || count_byte_errs() !== 0)
        $display("FAIL rand%0d_bytes: got %0d bytes %0d mismatches want %0d bytes", r, xfer_log.size(), count_byte_errs(), total*BPL); else pass_cnt++;
      chk_cnt++; if (ovl_errs !== 0) $display("FAIL rand%0d_overlap: got %0d multi-grant cycles want 0", r, ovl_errs); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_round_robin();
    test_first_priority();
    test_withdrawal();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
